// File: rtl/sfifo_wrr_sched.sv
// Weighted round-robin scheduler that drains NUM_Q show-ahead FIFOs into one
// registered valid/ready egress stage, tagging each word with its source queue.
module sfifo_wrr_sched #(
    parameter  int NUM_Q      = 4,
    parameter  int WIDTH_DATA = 32,
    parameter  int WIDTH_W    = 4,
    localparam int QID_W      = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          sched_en,
    input  logic [NUM_Q*WIDTH_W-1:0]      cfg_weight,
    input  logic [NUM_Q-1:0]              q_empty,
    input  logic [NUM_Q*WIDTH_DATA-1:0]   q_rdata,
    output logic [NUM_Q-1:0]              q_ren,
    output logic                          out_valid,
    output logic [WIDTH_DATA-1:0]         out_data,
    output logic [QID_W-1:0]              out_qid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int SUM_W = QID_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [QID_W-1:0]       grant_r;
    logic [QID_W-1:0]       grant_nxt_s;
    logic [QID_W-1:0]       rr_ptr_r;
    logic [QID_W-1:0]       rr_ptr_nxt_s;
    logic [QID_W-1:0]       grant_inc_s;
    logic [QID_W-1:0]       pick_q_s;
    logic                   pick_found_s;
    logic [WIDTH_W-1:0]     credit_r;
    logic [WIDTH_W-1:0]     credit_nxt_s;
    logic [NUM_Q-1:0]       eligible_s;
    logic [WIDTH_DATA-1:0]  rdata_arr_s  [NUM_Q];
    logic [WIDTH_W-1:0]     weight_arr_s [NUM_Q];
    logic                   head_empty_s;
    logic                   slot_free_s;
    logic                   pop_s;
    logic                   out_valid_r;
    logic [WIDTH_DATA-1:0]  out_data_r;
    logic [QID_W-1:0]       out_qid_r;

    // Unpack the flat per-queue buses; a queue is eligible when it has data and a non-zero weight.
    genvar g;
    generate
        for (g = 0; g < NUM_Q; g++) begin : g_unpack
            assign rdata_arr_s[g]  = q_rdata[g*WIDTH_DATA +: WIDTH_DATA];
            assign weight_arr_s[g] = cfg_weight[g*WIDTH_W +: WIDTH_W];
            assign eligible_s[g]   = !q_empty[g] && (weight_arr_s[g] != {WIDTH_W{1'b0}});
        end
    endgenerate

    assign head_empty_s = q_empty[grant_r];
    assign slot_free_s  = !out_valid_r || out_ready;
    assign pop_s        = (state_r == ST_SERVE) && sched_en && !head_empty_s && slot_free_s;
    assign grant_inc_s  = (grant_r == QID_W'(NUM_Q - 1)) ? {QID_W{1'b0}} : grant_r + QID_W'(1);
    assign busy         = (state_r == ST_SERVE);
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_qid      = out_qid_r;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_Q (works for non-power-of-two counts).
    always_comb begin
        logic [SUM_W-1:0] sum_s;
        logic [SUM_W-1:0] cand_s;
        logic             hit_s;
        pick_found_s = 1'b0;
        pick_q_s     = {QID_W{1'b0}};
        sum_s        = {SUM_W{1'b0}};
        cand_s       = {SUM_W{1'b0}};
        hit_s        = 1'b0;
        for (int k = 0; k < NUM_Q; k++) begin
            sum_s        = {1'b0, rr_ptr_r} + SUM_W'(k);
            cand_s       = (sum_s >= SUM_W'(NUM_Q)) ? (sum_s - SUM_W'(NUM_Q)) : sum_s;
            hit_s        = !pick_found_s && eligible_s[cand_s[QID_W-1:0]];
            pick_q_s     = hit_s ? cand_s[QID_W-1:0] : pick_q_s;
            pick_found_s = pick_found_s || hit_s;
        end
    end

    // Pop strobe for the granted queue only.
    always_comb begin
        q_ren          = {NUM_Q{1'b0}};
        q_ren[grant_r] = pop_s;
    end

    // Next-state logic: grant in IDLE, burst accounting and exit conditions in SERVE.
    always_comb begin
        state_nxt_s  = state_r;
        grant_nxt_s  = grant_r;
        rr_ptr_nxt_s = rr_ptr_r;
        credit_nxt_s = credit_r;
        case (state_r)
            ST_IDLE: begin
                if (sched_en && pick_found_s) begin
                    state_nxt_s  = ST_SERVE;
                    grant_nxt_s  = pick_q_s;
                    credit_nxt_s = weight_arr_s[pick_q_s];
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (!sched_en) begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = grant_inc_s;
                end else if (pop_s && (credit_r == WIDTH_W'(1))) begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = grant_inc_s;
                end else if (slot_free_s && head_empty_s) begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = grant_inc_s;
                end else if (pop_s) begin
                    credit_nxt_s = credit_r - WIDTH_W'(1);
                end else begin
                    // Downstream stall: an empty queue does not end the burst here.
                    state_nxt_s  = ST_SERVE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Scheduler state registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r  <= ST_IDLE;
            grant_r  <= {QID_W{1'b0}};
            rr_ptr_r <= {QID_W{1'b0}};
            credit_r <= {WIDTH_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            grant_r  <= grant_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            credit_r <= credit_nxt_s;
        end
    end

    // Egress register: load on pop, empty out when the slot frees without a pop, hold on stall.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH_DATA{1'b0}};
            out_qid_r   <= {QID_W{1'b0}};
        end else if (pop_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= rdata_arr_s[grant_r];
            out_qid_r   <= grant_r;
        end else if (slot_free_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_sfifo_wrr_sched.sv
// Scoreboard bench for sfifo_wrr_sched: FIFO models feed the DUT, expected words
// are queued on push and compared on every egress transfer.
module tb_sfifo_wrr_sched;

    localparam int NUM_Q      = 4;
    localparam int WIDTH_DATA = 32;
    localparam int WIDTH_W    = 4;
    localparam int QID_W      = 2;

    logic                        sys_clk;
    logic                        sys_rst;
    logic                        sched_en;
    logic [NUM_Q*WIDTH_W-1:0]    cfg_weight;
    logic [NUM_Q-1:0]            q_empty;
    logic [NUM_Q*WIDTH_DATA-1:0] q_rdata;
    logic [NUM_Q-1:0]            q_ren;
    logic                        out_valid;
    logic [WIDTH_DATA-1:0]       out_data;
    logic [QID_W-1:0]            out_qid;
    logic                        out_ready;
    logic                        busy;

    sfifo_wrr_sched #(.NUM_Q(NUM_Q), .WIDTH_DATA(WIDTH_DATA), .WIDTH_W(WIDTH_W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sched_en(sched_en), .cfg_weight(cfg_weight),
        .q_empty(q_empty), .q_rdata(q_rdata), .q_ren(q_ren), .out_valid(out_valid),
        .out_data(out_data), .out_qid(out_qid), .out_ready(out_ready), .busy(busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct { int qid; int gap; } seq_t;

    logic                 rdy_stg;
    logic                 en_stg;
    logic [15:0]          w_stg;
    logic [31:0]          fifo_m [NUM_Q][$];
    logic [31:0]          sb_m   [NUM_Q][$];
    seq_t                 seq_q  [$];
    int                   burst_hist [$];
    int                   pops_q [NUM_Q];
    int                   seq_n  [NUM_Q];
    int                   n_push [NUM_Q];
    int n_chk, n_pass, cyc, xfers, last_xfer_cyc, last_qid, burst_pops, burst_q, seq_mode;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic set_w(input int w0, input int w1, input int w2, input int w3);
        w_stg = {4'(w3), 4'(w2), 4'(w1), 4'(w0)};
    endtask

    task automatic push_word(input int q);
        logic [31:0] w;
        w = {8'(q), 24'(seq_n[q])};
        seq_n[q]++;
        n_push[q]++;
        fifo_m[q].push_back(w);
        sb_m[q].push_back(w);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_Q; i++) begin
            fifo_m[i].delete();
            sb_m[i].delete();
            pops_q[i] = 0;
            n_push[i] = 0;
        end
        seq_q.delete();
        burst_hist.delete();
        burst_pops = 0;
        seq_mode   = 0;
    endtask

    // Observe one cycle: q_ren / out_valid&out_ready seen here take effect at the next posedge.
    task automatic monitor();
        int rq;
        int qi;
        seq_t e;
        logic [31:0] exp_w;
        check_val("ren_onehot0", 64'($onehot0(q_ren)), 64'd1);
        check_val("ren_only_serve", 64'((q_ren != 4'b0000) && !busy), 64'd0);
        rq = -1;
        for (int i = 0; i < NUM_Q; i++) begin
            if (q_ren[i]) begin
                rq = i;
                pops_q[i]++;
                check_val("pop_nonempty", 64'(fifo_m[i].size() != 0), 64'd1);
                if (fifo_m[i].size() != 0) void'(fifo_m[i].pop_front());
            end
        end
        if (busy && rq >= 0) begin
            if (burst_pops == 0) burst_q = rq;
            else check_val("burst_same_q", 64'(rq), 64'(burst_q));
            burst_pops++;
            check_val("burst_le_weight", 64'(burst_pops <= int'(w_stg[burst_q*4 +: 4])), 64'd1);
        end else if (!busy) begin
            if (burst_pops != 0) burst_hist.push_back(burst_pops);
            burst_pops = 0;
        end
        if (out_valid && out_ready) begin
            xfers++;
            qi = int'(out_qid);
            if (sb_m[qi].size() == 0) begin
                check_val("sb_depth", 64'(sb_m[qi].size()), 64'd1);
            end else begin
                exp_w = sb_m[qi].pop_front();
                check_val("out_data", 64'(out_data), 64'(exp_w));
            end
            if (seq_mode != 0 && seq_q.size() > 0) begin
                e = seq_q.pop_front();
                check_val("qid_seq", 64'(out_qid), 64'(e.qid));
                if (e.gap > 0) check_val("burst_gap", 64'(cyc - last_xfer_cyc), 64'(e.gap));
            end
            last_xfer_cyc = cyc;
            last_qid      = qi;
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
        out_ready  = rdy_stg;
        sched_en   = en_stg;
        cfg_weight = w_stg;
        for (int i = 0; i < NUM_Q; i++) begin
            q_empty[i] = (fifo_m[i].size() == 0);
            q_rdata[i*WIDTH_DATA +: WIDTH_DATA] = (fifo_m[i].size() == 0) ? 32'h0 : fifo_m[i][0];
        end
        #1;
        cyc++;
        if (!sys_rst) monitor();
    endtask

    task automatic wait_xfers(input int target, input int bound, input string tag);
        int n;
        n = 0;
        while (xfers < target && n < bound) begin
            step();
            n++;
        end
        check_val(tag, 64'(xfers), 64'(target));
    endtask

    task automatic reset_dut();
        en_stg  = 1'b0;
        sys_rst = 1'b1;
        step();
        step();
        clear_all();
        sys_rst = 1'b0;
        step();
    endtask

    function automatic int last_burst();
        return (burst_hist.size() == 0) ? -1 : burst_hist[burst_hist.size()-1];
    endfunction

    initial begin
        int x;
        int n;
        logic [31:0] held;
        n_chk = 0; n_pass = 0; cyc = 0; xfers = 0; last_xfer_cyc = 0; last_qid = -1;
        for (int i = 0; i < NUM_Q; i++) seq_n[i] = 0;
        sys_rst = 1'b1; sched_en = 1'b0; out_ready = 1'b0; cfg_weight = 16'h0;
        q_empty = 4'hF; q_rdata = '0;
        rdy_stg = 1'b1; en_stg = 1'b0; w_stg = 16'h0;
        clear_all();
        #1;
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_data", 64'(out_data), 64'd0);
        check_val("rst_qid", 64'(out_qid), 64'd0);

        // Weighted service pattern 2,1,0,3 with every queue backlogged.
        reset_dut();
        set_w(2, 1, 0, 3);
        for (int i = 0; i < NUM_Q; i++) for (int k = 0; k < 30; k++) push_word(i);
        for (int r = 0; r < 5; r++) begin
            seq_q.push_back('{qid: 0, gap: (r == 0) ? 0 : 2});
            seq_q.push_back('{qid: 0, gap: 1});
            seq_q.push_back('{qid: 1, gap: 2});
            seq_q.push_back('{qid: 3, gap: 2});
            seq_q.push_back('{qid: 3, gap: 1});
            seq_q.push_back('{qid: 3, gap: 1});
        end
        seq_mode = 1;
        en_stg   = 1'b1;
        wait_xfers(xfers + 30, 120, "wrr_words");
        check_val("wrr_q2_untouched", 64'(fifo_m[2].size()), 64'd30);
        seq_mode = 0;

        // Asynchronous reset in the middle of a burst.
        n = 0;
        while (!(busy && out_valid) && n < 20) begin
            step();
            n++;
        end
        check_val("pre_rst_busy", 64'(busy), 64'd1);
        check_val("pre_rst_valid", 64'(out_valid), 64'd1);
        en_stg  = 1'b0;
        sys_rst = 1'b1;
        #1;
        check_val("midrst_valid", 64'(out_valid), 64'd0);
        check_val("midrst_ren", 64'(q_ren), 64'd0);
        check_val("midrst_busy", 64'(busy), 64'd0);
        step();
        clear_all();
        sys_rst = 1'b0;
        step();
        set_w(1, 1, 1, 1);
        for (int i = 0; i < NUM_Q; i++) push_word(i);
        en_stg = 1'b1;
        x = xfers;
        wait_xfers(x + 1, 10, "post_rst_word");
        check_val("post_rst_first_q0", 64'(last_qid), 64'd0);
        wait_xfers(x + 4, 20, "post_rst_drain");

        // Burst ends on an empty queue, then the queue is regranted later.
        reset_dut();
        set_w(5, 5, 5, 5);
        push_word(1);
        push_word(1);
        en_stg = 1'b1;
        wait_xfers(xfers + 2, 20, "drain_words");
        check_val("drain_qid", 64'(last_qid), 64'd1);
        step(); step(); step();
        check_val("drain_idle", 64'(busy), 64'd0);
        check_val("drain_burst_len", 64'(last_burst()), 64'd2);
        push_word(1);
        wait_xfers(xfers + 1, 20, "regrant_word");
        check_val("regrant_q1", 64'(last_qid), 64'd1);

        // Five-cycle backpressure in the middle of an 8-word burst.
        reset_dut();
        set_w(8, 8, 8, 8);
        for (int k = 0; k < 10; k++) push_word(0);
        en_stg = 1'b1;
        x = xfers;
        wait_xfers(x + 2, 20, "bp_start");
        rdy_stg = 1'b0;
        step();
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            check_val("bp_valid", 64'(out_valid), 64'd1);
            check_val("bp_hold_data", 64'(out_data), 64'(held));
            check_val("bp_no_pop", 64'(q_ren), 64'd0);
            check_val("bp_busy", 64'(busy), 64'd1);
        end
        rdy_stg = 1'b1;
        wait_xfers(x + 10, 40, "bp_done");
        check_val("bp_first_burst", 64'((burst_hist.size() > 0) ? burst_hist[0] : -1), 64'd8);

        // Abort a q2 burst with credit 3 left; re-enable must start at q3.
        reset_dut();
        set_w(0, 0, 5, 2);
        for (int i = 0; i < NUM_Q; i++) for (int k = 0; k < 6; k++) push_word(i);
        en_stg = 1'b1;
        n = 0;
        while (pops_q[2] < 2 && n < 20) begin
            step();
            n++;
        end
        check_val("abort_q2_pops", 64'(pops_q[2]), 64'd2);
        en_stg = 1'b0;
        step();
        check_val("abort_no_pop", 64'(q_ren), 64'd0);
        check_val("abort_serve_cycle", 64'(busy), 64'd1);
        step();
        check_val("abort_idle", 64'(busy), 64'd0);
        check_val("abort_burst_len", 64'(last_burst()), 64'd2);
        set_w(1, 1, 5, 2);
        step();
        step();
        x = xfers;
        en_stg = 1'b1;
        wait_xfers(x + 1, 10, "reen_word");
        check_val("reen_first_q3", 64'(last_qid), 64'd3);

        // Random traffic, backpressure and enable toggling.
        reset_dut();
        w_stg = 16'($urandom_range(0, 65535));
        w_stg[7:4] = 4'($urandom_range(1, 15));
        en_stg = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM_Q; i++)
                if (fifo_m[i].size() < 16 && $urandom_range(0, 3) == 0) push_word(i);
            rdy_stg = ($urandom_range(0, 3) != 0);
            en_stg  = ($urandom_range(0, 49) != 0);
            step();
        end
        rdy_stg = 1'b1;
        en_stg  = 1'b1;
        n = 0;
        while (n < 3000) begin
            x = 0;
            for (int i = 0; i < NUM_Q; i++) if (w_stg[i*4 +: 4] != 4'h0) x += sb_m[i].size();
            if (x == 0) break;
            step();
            n++;
        end
        for (int i = 0; i < NUM_Q; i++) begin
            if (w_stg[i*4 +: 4] == 4'h0) check_val("rand_w0_untouched", 64'(sb_m[i].size()), 64'(n_push[i]));
            else check_val("rand_drained", 64'(sb_m[i].size()), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sfifo_wrr_sched.md
Name: sfifo_wrr_sched

Overview:
- Weighted round-robin scheduler that shares one egress datapath between NUM_Q per-tenant show-ahead sfifo queues (SHOW_AHEAD=1, OUT_REGISTERED=0).
- Grants one queue at a time for a burst of up to cfg_weight words, pops words via per-queue read enables, and registers them into a single valid/ready output stage tagged with the queue id.
- Sits between the per-tenant TX FIFOs and the shared TX engine; it provides bandwidth isolation.

Parameters:
- NUM_Q, 4: number of queues, 2..16. QID_W = max(1, clog2(NUM_Q)) is derived as a localparam.
- WIDTH_DATA, 32: data word width; must match the FIFO WIDTH_DATA.
- WIDTH_W, 4: per-queue weight width; the burst limit is cfg_weight value in words.

Ports:
- sys_clk, in, 1: clock.
- sys_rst, in, 1: reset, asynchronous, active-high.
- sched_en, in, 1: global scheduler enable.
- cfg_weight, in, NUM_Q*WIDTH_W: weight of queue i at bits [i*WIDTH_W +: WIDTH_W]. 0 disables the queue.
- q_empty, in, NUM_Q: FIFO empty flags.
- q_rdata, in, NUM_Q*WIDTH_DATA: show-ahead FIFO data, slice i valid while q_empty[i]=0.
- q_ren, out, NUM_Q: FIFO read/pop strobes, combinational, at most one bit high.
- out_valid, out, 1: output word valid.
- out_data, out, WIDTH_DATA: output word.
- out_qid, out, QID_W: source queue of out_data.
- out_ready, in, 1: downstream accept.
- busy, out, 1: high while in SERVE.

Behaviour:
- Reset (async) values:
  - out_valid=0, out_data=0, out_qid=0, busy=0, q_ren=0.
  - state=IDLE, grant_q=0, rr_ptr=0, credit=0.
- Output stage:
  - slot_free = !out_valid | out_ready.
  - Transfer occurs when out_valid & out_ready.
  - out_valid/out_data/out_qid hold stable while out_valid=1 and out_ready=0.
- Pop condition: pop = (state==SERVE) & sched_en & !q_empty[grant_q] & slot_free.
  - q_ren[grant_q]=pop; all other q_ren bits are 0.
  - On pop, the next edge loads out_data<=q_rdata[grant_q], out_qid<=grant_q, out_valid<=1.
  - On slot_free without pop, out_valid<=0.
  - Latency: one cycle from pop to out_valid.
  - Sustained throughput is 1 word/clk while out_ready=1.
- IDLE:
  - If sched_en=1, search queues rr_ptr, rr_ptr+1, ... wrapping NUM_Q-1 to 0.
  - The first queue with q_empty=0 and weight!=0 is chosen: grant_q<=it, credit<=its weight, then go to SERVE.
  - Otherwise stay in IDLE. No pop occurs in IDLE, so each grant costs one bubble cycle.
  - Weight is sampled only at grant; changes mid-burst take effect on the next grant.
- SERVE, with priority order:
  - (a) sched_en=0: go to IDLE; rr_ptr<=grant_q+1 mod NUM_Q.
  - (b) pop and credit==1: go to IDLE; rr_ptr<=grant_q+1.
  - (c) slot_free and q_empty[grant_q]=1: queue drained; go to IDLE; rr_ptr<=grant_q+1.
  - (d) pop: credit<=credit-1 and stay in SERVE.
  - (e) otherwise (downstream stall): hold state and credit. Emptiness during a stall does not end the burst.
- Credit never reaches 0 within SERVE. credit is WIDTH_W bits; no underflow is possible.
- busy = (state==SERVE).
- sched_en deassertion aborts the burst immediately, with no pop that cycle. The already-registered output word still completes normally.
- Single eligible queue: it is regranted after one IDLE bubble per burst.
- All weights 0, or all queues empty: remain in IDLE with q_ren=0.
- Overflow/underflow protection of the FIFOs is the FIFO's own job. The scheduler never pops a queue while its q_empty=1.

Test Plan:
- Reset mid-burst: assert sys_rst while SERVE with out_valid=1 → same cycle out_valid=0, q_ren=0, busy=0. After release, the first grant goes to q0 if eligible.
- NUM_Q=4, weights 2,1,0,3, all queues full, out_ready=1 → out_qid sequence 0,0,1,3,3,3,0,0,1,...; q2 is never popped; one bubble between bursts.
- q1 holds 2 words with weight 5, others empty → 2 words are output with qid=1, the burst exits on empty, and the scheduler returns to IDLE. A later write to q1 is regranted.
- Backpressure: out_ready=0 for 5 cycles mid-burst → out_data stable, q_ren=0, credit unchanged. Release → words continue in order with no loss or duplication.
- Drop sched_en during a q2 burst with credit 3 → immediate IDLE, rr_ptr=3. Re-enable → q3 is granted first if eligible.
- Random traffic over 10k cycles, checked against a scoreboard model → per-queue ordering is preserved, q_ren is one-hot-or-zero, no pop of an empty queue, and per-burst word count ≤ weight.
